muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports: it takes the two source operands read for an M-extension instruction, computes the result over multiple cycles, and presents the result, destination index and write enable for the register file write port. A start/busy/done handshake stalls the core while the unit computes. Target is one 32-iteration shift-add / restoring-divide datapath shared by all eight operations.

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared 32-step shift-add / restoring
// divide datapath behind a start/busy/done handshake feeding the register file write port.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        we_out
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd_lat;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opnd;
    logic              r_neg;
    logic              r_busy;
    logic              r_done;
    logic              r_we;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_overflow;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [XLEN-1:0]   w_next_hi;
    logic [XLEN-1:0]   w_next_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_val;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_fix_res;

    // Request decode: operand signedness, magnitudes and special-case detection
    always_comb begin
        w_is_div   = funct3[2];
        w_a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                     (funct3 == F_DIV)  || (funct3 == F_REM);
        w_b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        w_a_neg    = w_a_signed && op_a[XLEN-1];
        w_b_neg    = w_b_signed && op_b[XLEN-1];
        w_a_mag    = w_a_neg ? XLEN'(~op_a + 32'd1) : op_a;
        w_b_mag    = w_b_neg ? XLEN'(~op_b + 32'd1) : op_b;
        w_div_zero = w_is_div && (op_b == '0);
        w_overflow = w_is_div && !funct3[0] &&
                     (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
        end else if (w_overflow) begin
            w_special_res = funct3[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_next_hi   = w_mul_sum[XLEN:1];
        w_next_lo   = {w_mul_sum[0], r_lo[XLEN-1:1]};
        if (r_funct3[2]) begin
            w_next_hi = w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
            w_next_lo = {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
        end
    end

    // Sign correction and output selection for the FIX step
    always_comb begin
        w_prod     = {r_hi, r_lo};
        w_prod_fix = r_neg ? (2*XLEN)'(~w_prod + 64'd1) : w_prod;
        w_div_val  = r_funct3[1] ? r_hi : r_lo;
        w_div_fix  = r_neg ? XLEN'(~w_div_val + 32'd1) : w_div_val;
        if (r_funct3[2]) begin
            w_fix_res = w_div_fix;
        end else if (r_funct3 == F_MUL) begin
            w_fix_res = w_prod_fix[XLEN-1:0];
        end else begin
            w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_funct3 <= '0;
            r_rd_lat <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_we   <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_funct3 <= funct3;
                        r_rd_lat <= rd_in;
                        // Remainder takes the dividend's sign; everything else the XOR
                        r_neg    <= (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                        if (w_div_zero || w_overflow) begin
                            r_result <= w_special_res;
                            r_rd_out <= rd_in;
                            r_done   <= 1'b1;
                            r_we     <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_count  <= '0;
                            r_hi     <= '0;
                            r_lo     <= w_is_div ? w_a_mag : w_b_mag;
                            r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_hi    <= w_next_hi;
                    r_lo    <= w_next_lo;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(XLEN - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_rd_out <= r_rd_lat;
                    r_done   <= 1'b1;
                    r_we     <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign we_out = r_we;
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency and handshake timing.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    int checks   = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we_out (we_out)
    );

    always #5 clk = ~clk;

    // Directed vectors: funct3, op_a, op_b, expected result
    localparam logic [2:0]  MH_F [3] = '{3'b001, 3'b011, 3'b010};
    localparam logic [31:0] MH_A [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] MH_B [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] MH_R [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

    localparam logic [2:0]  DV_F [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    localparam logic [31:0] DV_A [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    localparam logic [31:0] DV_B [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    localparam logic [31:0] DV_R [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};

    localparam logic [2:0]  SP_F [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    localparam logic [31:0] SP_A [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    localparam logic [31:0] SP_B [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] SP_R [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    // Issues one request from IDLE and returns at the first cycle done is seen.
    // lat counts edges after the accepting edge; -1 means no done within the budget.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic busy0,
                         output logic [31:0] res, output logic [4:0] rdo);
        @(posedge clk); #1;
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'b000; op_a = 32'hDEAD_BEEF; op_b = 32'h0; rd_in = 5'd0;
        busy0 = busy;
        lat = -1;
        for (int i = 0; i <= 100; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        res = result;
        rdo = rd_out;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (we_out !== 1'b0)   begin failures++; $display("FAIL reset_we got=%b exp=0", we_out); end
        if (result !== 32'h0)  begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        if (rd_out !== 5'h0)   begin failures++; $display("FAIL reset_rd got=%h exp=0", rd_out); end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        int lat; logic b0; logic [31:0] res; logic [4:0] rdo; logic we_at_done;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, b0, res, rdo);
        we_at_done = we_out;
        checks += 5;
        if (b0 !== 1'b1)          begin failures++; $display("FAIL mul_busy got=%b exp=1", b0); end
        if (lat != 33)            begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        if (res !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
        if (rdo !== 5'd5)         begin failures++; $display("FAIL mul_rd got=%0d exp=5", rdo); end
        if (we_at_done !== 1'b1)  begin failures++; $display("FAIL mul_we got=%b exp=1", we_at_done); end
        @(posedge clk); #1;
        checks += 4;
        if (we_out !== 1'b0)      begin failures++; $display("FAIL mul_we_pulse got=%b exp=0", we_out); end
        if (done !== 1'b0)        begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL mul_busy_fall got=%b exp=0", busy); end
        if (result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_hold got=%h exp=ffffffeb", result); end
    endtask

    task automatic test_mulh();
        int lat; logic b0; logic [31:0] res; logic [4:0] rdo;
        for (int k = 0; k < 3; k++) begin
            do_op(MH_F[k], MH_A[k], MH_B[k], 5'(k + 10), lat, b0, res, rdo);
            checks += 2;
            if (res !== MH_R[k]) begin failures++; $display("FAIL mulh_%0d result got=%h exp=%h", k, res, MH_R[k]); end
            if (lat != 33)       begin failures++; $display("FAIL mulh_%0d latency got=%0d exp=33", k, lat); end
        end
    endtask

    task automatic test_div();
        int lat; logic b0; logic [31:0] res; logic [4:0] rdo;
        for (int k = 0; k < 4; k++) begin
            do_op(DV_F[k], DV_A[k], DV_B[k], 5'(k + 20), lat, b0, res, rdo);
            checks += 3;
            if (res !== DV_R[k])    begin failures++; $display("FAIL div_%0d result got=%h exp=%h", k, res, DV_R[k]); end
            if (lat != 33)          begin failures++; $display("FAIL div_%0d latency got=%0d exp=33", k, lat); end
            if (rdo !== 5'(k + 20)) begin failures++; $display("FAIL div_%0d rd got=%0d exp=%0d", k, rdo, k + 20); end
        end
    endtask

    task automatic test_special();
        int lat; logic b0; logic [31:0] res; logic [4:0] rdo;
        for (int k = 0; k < 4; k++) begin
            do_op(SP_F[k], SP_A[k], SP_B[k], 5'(k + 1), lat, b0, res, rdo);
            checks += 3;
            if (res !== SP_R[k]) begin failures++; $display("FAIL special_%0d result got=%h exp=%h", k, res, SP_R[k]); end
            if (lat != 0)        begin failures++; $display("FAIL special_%0d latency got=%0d exp=0", k, lat); end
            if (b0 !== 1'b1)     begin failures++; $display("FAIL special_%0d busy got=%b exp=1", k, b0); end
        end
    endtask

    // start held high across three ops: accepts only at the first IDLE cycle
    task automatic test_back_to_back();
        int ndone = 0;
        int d[3] = '{0, 0, 0};
        logic [31:0] r0 = '0;
        logic b35 = 1'b1;
        logic b36 = 1'b0;
        @(posedge clk); #1;
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd9; start = 1'b1;
        for (int i = 1; i <= 106; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (ndone < 3) d[ndone] = i;
                if (ndone == 0) r0 = result;
                ndone++;
            end
            if (i == 35) b35 = busy;
            if (i == 36) b36 = busy;
            if (i == 104) start = 1'b0;
        end
        checks += 7;
        if (ndone != 3)       begin failures++; $display("FAIL b2b_count got=%0d exp=3", ndone); end
        if (d[0] != 34)       begin failures++; $display("FAIL b2b_done0 got=%0d exp=34", d[0]); end
        if (d[1] != 69)       begin failures++; $display("FAIL b2b_done1 got=%0d exp=69", d[1]); end
        if (d[2] != 104)      begin failures++; $display("FAIL b2b_done2 got=%0d exp=104", d[2]); end
        if (r0 !== 32'd15)    begin failures++; $display("FAIL b2b_result got=%h exp=f", r0); end
        if (b35 !== 1'b0)     begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", b35); end
        if (b36 !== 1'b1)     begin failures++; $display("FAIL b2b_reaccept got=%b exp=1", b36); end
    endtask

    task automatic test_reset_midop();
        int lat; logic b0; logic [31:0] res; logic [4:0] rdo;
        @(posedge clk); #1;
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd12; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks += 4;
        if (busy !== 1'b0)    begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        if (result !== 32'h0) begin failures++; $display("FAIL midrst_result got=%h exp=0", result); end
        if (rd_out !== 5'h0)  begin failures++; $display("FAIL midrst_rd got=%0d exp=0", rd_out); end
        do_op(3'b101, 32'd9, 32'd3, 5'd7, lat, b0, res, rdo);
        checks += 3;
        if (res !== 32'd3) begin failures++; $display("FAIL post_rst_result got=%h exp=3", res); end
        if (lat != 33)     begin failures++; $display("FAIL post_rst_latency got=%0d exp=33", lat); end
        if (rdo !== 5'd7)  begin failures++; $display("FAIL post_rst_rd got=%0d exp=7", rdo); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
